// File: rtl/wr_trans_sched.sv
// Round-robin write-transaction scheduler that launches a shared AW/W/B handler trio.
// Defining WR_SCHED_TIMEOUT_EN adds a watchdog that bounds the WAIT state.
package wr_trans_sched_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  burst_len;
  } trans_data_t;
endpackage

// state  | meaning
// IDLE   | arbitrate requesters, accept or reject one descriptor per cycle
// LAUNCH | hold until all handlers are ready, then pulse the three enables
// WAIT   | wait for all handlers to return to ready (first cycle ignored)
module wr_trans_sched
  import wr_trans_sched_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  trans_data_t [NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output trans_data_t               trans_data_o,
  output logic                      aw_en_o,
  output logic                      w_en_o,
  output logic                      b_en_o,
  input  logic                      aw_ready_i,
  input  logic                      w_ready_i,
  input  logic                      b_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      timeout_o,
  output logic [ID_W-1:0]           resp_id_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
    $error("wr_trans_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   id_q;
  trans_data_t       trans_data_q;
  logic              err_q;
  logic              wait_first_q;

  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   rr_nxt;
  logic [ID_W:0]     sum;
  logic              any_valid;
  logic              all_ready;
  logic              launch;
  logic              done_w;
  logic              timeout_w;

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    win       = rr_q;
    any_valid = 1'b0;
    sum       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (req_valid_i[sum[ID_W-1:0]]) begin
        win       = sum[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign rr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && any_valid) req_ready_o[win] = 1'b1;
  end

  assign all_ready = aw_ready_i && w_ready_i && b_ready_i;
  assign launch    = (state_q == LAUNCH) && all_ready;
  assign done_w    = (state_q == WAIT) && !wait_first_q && all_ready;

`ifdef WR_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  // Counter reads k-1 in the k-th WAIT cycle, so the limit fires in cycle TIMEOUT_CYCLES.
  assign timeout_w = (state_q == WAIT) && !done_w && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      trans_data_q <= '0;
      err_q        <= 1'b0;
      wait_first_q <= 1'b0;
`ifdef WR_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            trans_data_q <= req_data_i[win];
            id_q         <= win;
            rr_q         <= rr_nxt;
            // A zero-length burst would underflow the handlers' beat counters.
            if (req_data_i[win].burst_len == 8'd0) err_q   <= 1'b1;
            else                                   state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (all_ready) begin
            state_q      <= WAIT;
            wait_first_q <= 1'b1;
`ifdef WR_SCHED_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
          end
        end
        WAIT: begin
          wait_first_q <= 1'b0;
`ifdef WR_SCHED_TIMEOUT_EN
          wait_cnt_q   <= wait_cnt_q + 16'd1;
`endif
          if (done_w || timeout_w) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trans_data_o = trans_data_q;
  assign aw_en_o      = launch;
  assign w_en_o       = launch;
  assign b_en_o       = launch;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_w;
  assign err_o        = err_q;
  assign timeout_o    = timeout_w;
  assign resp_id_o    = id_q;

endmodule

// File: tb/tb_wr_trans_sched.sv
// Directed bench for wr_trans_sched: table of single transactions plus
// hand-written sequences for stalled launch, reject+accept, reset and watchdog.
module tb_wr_trans_sched;
  import wr_trans_sched_pkg::*;

  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_valid_i;
  trans_data_t [N-1:0] req_data_i;
  logic [N-1:0]      req_ready_o;
  trans_data_t       trans_data_o;
  logic              aw_en_o, w_en_o, b_en_o;
  logic              aw_ready_i, w_ready_i, b_ready_i;
  logic              busy_o, done_o, err_o, timeout_o;
  logic [1:0]        resp_id_o;

  int total = 0;
  int bad   = 0;

  wr_trans_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .trans_data_o(trans_data_o),
    .aw_en_o(aw_en_o), .w_en_o(w_en_o), .b_en_o(b_en_o),
    .aw_ready_i(aw_ready_i), .w_ready_i(w_ready_i), .b_ready_i(b_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o),
    .resp_id_o(resp_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] blen;
    int         occ;
    logic [3:0] exp_grant;
    int         exp_id;
    bit         exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] blen);
    for (int r = 0; r < N; r++) begin
      req_data_i[r].addr      = 16'h1000 + 16'(r);
      req_data_i[r].burst_len = blen;
    end
  endtask

  function automatic logic [31:0] exp_data(input int id, input logic [7:0] blen);
    trans_data_t t;
    t.addr      = 16'h1000 + 16'(id);
    t.burst_len = blen;
    return 32'(t);
  endfunction

  task automatic set_ready(input logic v);
    aw_ready_i = v; w_ready_i = v; b_ready_i = v;
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] ens();
    return 32'({aw_en_o, w_en_o, b_en_o});
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    req_valid_i = v.mask;
    set_data(v.blen);
    set_ready(1'b1);
    @(negedge clk_i);
    chk({p, "_idle_busy"}, 32'(busy_o), 0);
    chk({p, "_grant"}, 32'(req_ready_o), 32'(v.exp_grant));
    next_cyc();
    req_valid_i = v.mask & ~v.exp_grant;
    if (v.exp_err) begin
      @(negedge clk_i);
      chk({p, "_err"}, 32'(err_o), 1);
      chk({p, "_err_id"}, 32'(resp_id_o), 32'(v.exp_id));
      chk({p, "_err_noen"}, ens(), 0);
      chk({p, "_err_busy"}, 32'(busy_o), 0);
      next_cyc();
      return;
    end
    @(negedge clk_i);
    chk({p, "_en"}, ens(), 32'h7);
    chk({p, "_data"}, 32'(trans_data_o), exp_data(v.exp_id, v.blen));
    chk({p, "_launch_nogrant"}, 32'(req_ready_o), 0);
    next_cyc();
    set_ready(v.occ == 0);
    @(negedge clk_i);
    chk({p, "_wait1_nodone"}, 32'(done_o), 0);
    chk({p, "_wait1_noen"}, ens(), 0);
    chk({p, "_wait1_busy"}, 32'(busy_o), 1);
    next_cyc();
    for (int k = 1; k < v.occ; k++) begin
      set_ready(1'b0);
      @(negedge clk_i);
      chk({p, "_wait_nodone"}, 32'(done_o), 0);
      chk({p, "_wait_nogrant"}, 32'(req_ready_o), 0);
      next_cyc();
    end
    set_ready(1'b1);
    @(negedge clk_i);
    chk({p, "_done"}, 32'(done_o), 1);
    chk({p, "_done_id"}, 32'(resp_id_o), 32'(v.exp_id));
    chk({p, "_done_nogrant"}, 32'(req_ready_o), 0);
    chk({p, "_done_data"}, 32'(trans_data_o), exp_data(v.exp_id, v.blen));
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Round-robin pointer after each row is noted on the right.
    vecs[0]  = '{4'b0100, 8'd4,   6, 4'b0100, 2, 1'b0}; // rr 3
    vecs[1]  = '{4'b1111, 8'd1,   2, 4'b1000, 3, 1'b0}; // rr 0
    vecs[2]  = '{4'b1111, 8'd2,   1, 4'b0001, 0, 1'b0}; // rr 1
    vecs[3]  = '{4'b1111, 8'd3,   0, 4'b0010, 1, 1'b0}; // rr 2
    vecs[4]  = '{4'b1111, 8'd1,   3, 4'b0100, 2, 1'b0}; // rr 3
    vecs[5]  = '{4'b1111, 8'd1,   1, 4'b1000, 3, 1'b0}; // rr 0
    vecs[6]  = '{4'b1111, 8'd1,   1, 4'b0001, 0, 1'b0}; // rr 1
    vecs[7]  = '{4'b0010, 8'd0,   0, 4'b0010, 1, 1'b1}; // rr 2
    vecs[8]  = '{4'b1111, 8'd2,   2, 4'b0100, 2, 1'b0}; // rr 3
    vecs[9]  = '{4'b0011, 8'd1,   1, 4'b0001, 0, 1'b0}; // rr 1
    vecs[10] = '{4'b1001, 8'd1,   1, 4'b1000, 3, 1'b0}; // rr 0
    vecs[11] = '{4'b1000, 8'hff,  1, 4'b1000, 3, 1'b0}; // rr 0
    vecs[12] = '{4'b1000, 8'd0,   0, 4'b1000, 3, 1'b1}; // rr 0
    vecs[13] = '{4'b0001, 8'd1,   1, 4'b0001, 0, 1'b0}; // rr 1

    rst_ni      = 1'b0;
    req_valid_i = '0;
    set_data(8'd0);
    set_ready(1'b1);
    #2;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_en", ens(), 0);
    chk("rst_data", 32'(trans_data_o), 0);
    chk("rst_id", 32'(resp_id_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    #10 rst_ni = 1'b1;
    next_cyc();

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Launch stalled by b_ready_i low for 5 cycles.
    req_valid_i = 4'b0001;
    set_data(8'd3);
    @(negedge clk_i);
    chk("stall_grant", 32'(req_ready_o), 32'h1);
    next_cyc();
    req_valid_i = '0;
    for (int k = 0; k < 5; k++) begin
      b_ready_i = 1'b0;
      @(negedge clk_i);
      chk("stall_noen", ens(), 0);
      chk("stall_busy", 32'(busy_o), 1);
      next_cyc();
    end
    b_ready_i = 1'b1;
    @(negedge clk_i);
    chk("stall_en", ens(), 32'h7);
    next_cyc();
    set_ready(1'b0);
    @(negedge clk_i);
    chk("stall_wait_nodone", 32'(done_o), 0);
    next_cyc();
    set_ready(1'b1);
    @(negedge clk_i);
    chk("stall_done", 32'(done_o), 1);
    chk("stall_done_id", 32'(resp_id_o), 0);
    next_cyc();

    // Reset asserted in the middle of WAIT; rr returns to 0.
    req_valid_i = 4'b0100;
    set_data(8'd2);
    @(negedge clk_i);
    chk("rstw_grant", 32'(req_ready_o), 32'h4);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk_i);
    chk("rstw_en", ens(), 32'h7);
    next_cyc();
    set_ready(1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy_o), 0);
    chk("rstw_done", 32'(done_o), 0);
    chk("rstw_en_low", ens(), 0);
    chk("rstw_data", 32'(trans_data_o), 0);
    chk("rstw_id", 32'(resp_id_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    next_cyc();
    run_txn('{4'b1111, 8'd1, 1, 4'b0001, 0, 1'b0}, 100); // rr 1

    // Rejected descriptor from req 1 while req 2 waits: req 2 accepted in the err cycle.
    req_valid_i = 4'b0110;
    set_data(8'd5);
    req_data_i[1].burst_len = 8'd0;
    set_ready(1'b1);
    @(negedge clk_i);
    chk("rej_grant", 32'(req_ready_o), 32'h2);
    next_cyc();
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    chk("rej_err", 32'(err_o), 1);
    chk("rej_err_id", 32'(resp_id_o), 1);
    chk("rej_regrant", 32'(req_ready_o), 32'h4);
    chk("rej_noen", ens(), 0);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk_i);
    chk("rej_err_pulse", 32'(err_o), 0);
    chk("rej_en", ens(), 32'h7);
    chk("rej_data", 32'(trans_data_o), exp_data(2, 8'd5));
    next_cyc();
    set_ready(1'b0);
    @(negedge clk_i);
    chk("rej_wait_nodone", 32'(done_o), 0);
    next_cyc();
    set_ready(1'b1);
    @(negedge clk_i);
    chk("rej_done", 32'(done_o), 1);
    chk("rej_done_id", 32'(resp_id_o), 2);
    next_cyc(); // rr 3

    // b_ready_i stuck low in WAIT.
    req_valid_i = 4'b1000;
    set_data(8'd1);
    @(negedge clk_i);
    chk("to_grant", 32'(req_ready_o), 32'h8);
    next_cyc();
    req_valid_i = '0;
    @(negedge clk_i);
    chk("to_en", ens(), 32'h7);
    next_cyc();
    for (int k = 1; k <= 20; k++) begin
      aw_ready_i = (k > 1);
      w_ready_i  = (k > 1);
      b_ready_i  = 1'b0;
      @(negedge clk_i);
      chk("to_nodone", 32'(done_o), 0);
`ifdef WR_SCHED_TIMEOUT_EN
      chk("to_pulse", 32'(timeout_o), 32'(k == 20));
      if (k == 20) chk("to_id", 32'(resp_id_o), 3);
`else
      chk("to_never", 32'(timeout_o), 0);
`endif
      next_cyc();
    end
`ifdef WR_SCHED_TIMEOUT_EN
    @(negedge clk_i);
    chk("to_idle", 32'(busy_o), 0);
    chk("to_single", 32'(timeout_o), 0);
    chk("to_nodone_after", 32'(done_o), 0);
    next_cyc();
`else
    b_ready_i = 1'b1;
    @(negedge clk_i);
    chk("to_done", 32'(done_o), 1);
    chk("to_done_id", 32'(resp_id_o), 3);
    next_cyc();
    @(negedge clk_i);
    chk("to_idle", 32'(busy_o), 0);
    next_cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
